pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Sequences the system PLL (three-output PLLA, 50 MHz reference) from power-up to a safe running state.
- Drives the PLL reset, qualifies the asynchronous PLL lock with a synchroniser and stability filter, and retries on timeout.
- Releases per-domain resets one after another and re-sequences when lock is lost.
- Runs on the 50 MHz reference clock, upstream of every SoC reset synchroniser.

Parameters:
- RST_CYCLES, 16: cycles pll_reset is held high per attempt (min 1).
- STABLE_CYCLES, 1024: consecutive synchronised-lock-high cycles required before lock counts as valid.
- TIMEOUT_CYCLES, 65536: cycles allowed in WAIT_LOCK before a retry.
- MAX_RETRY, 7: maximum number of retries before FAIL (min 1).
- N_OUT, 3: number of domain resets; matches the PLL outputs in use.
- STAGGER_CYCLES, 8: gap between successive domain-reset releases.

Ports:
- clkin, input, 1: 50 MHz reference clock.
- reset, input, 1: asynchronous, active-high. Assertion is asynchronous; deassertion is used as-is and is already synchronous to clkin upstream.
- lock, input, 1: raw PLL lock, asynchronous to clkin.
- restart, input, 1: single-cycle pulse requesting a full re-sequence.
- pll_reset, output, 1: reset to the PLL.
- rst_out, output, N_OUT: active-high domain resets. Bit i is for PLL clkout i.
- ready, output, 1: high in RUN only.
- fail, output, 1: high in FAIL only.
- retry_cnt, output, 3: number of retries in the current sequence. Saturates at 7.
- lock_lost, output, 1: sticky flag, set when lock drops during RUN.

Behaviour:
- Reset values: pll_reset=1, rst_out=all ones, ready=0, fail=0, retry_cnt=0, lock_lost=0, state=PLL_RST, all counters=0.
- Lock synchronisation: 2-flop synchroniser on lock, giving lock_s. All decisions below use lock_s, which adds 2 cycles of latency.
- Stability counter:
  - Counts while lock_s=1 in WAIT_LOCK.
  - Clears to 0 on any cycle with lock_s=0.
- State PLL_RST:
  - pll_reset=1, rst_out=all ones.
  - After RST_CYCLES cycles, go to WAIT_LOCK and clear the timeout and stability counters.
- State WAIT_LOCK:
  - pll_reset=0.
  - If the stability counter reaches STABLE_CYCLES, go to RELEASE. This check has priority over the timeout when both occur in the same cycle.
  - Else if the timeout counter reaches TIMEOUT_CYCLES:
    - If retry_cnt < MAX_RETRY: increment retry_cnt and go to PLL_RST.
    - Otherwise go to FAIL.
- State RELEASE:
  - Bit 0 of rst_out deasserts on the first RELEASE cycle.
  - Bit i deasserts i*STAGGER_CYCLES cycles later.
  - One cycle after bit N_OUT-1 deasserts, go to RUN.
  - If lock_s=0 during RELEASE: set rst_out to all ones and go to PLL_RST. Do not set lock_lost.
- State RUN:
  - ready=1, rst_out=0.
  - If lock_s=0: set lock_lost, set rst_out to all ones in the same cycle, and go to PLL_RST.
  - retry_cnt is not cleared on this path.
- State FAIL:
  - pll_reset=1, rst_out=all ones, fail=1.
  - Leave only on restart or reset.
- restart:
  - Accepted in any state, including FAIL.
  - Goes to PLL_RST, clears retry_cnt and lock_lost, and sets rst_out to all ones on the next edge.
  - Takes priority over every other transition.
- Output timing: all outputs are registered. rst_out bits only go high together, never individually.
- retry_cnt counts lock timeouts only. Re-sequences caused by lock loss or restart do not increment it.
- Asynchronous reset mid-sequence immediately forces the reset values, whatever the current state.

Test Plan:
- Normal lock: RST_CYCLES=4, STABLE_CYCLES=8, STAGGER_CYCLES=2, N_OUT=3. Raise lock 10 cycles after reset deassertion.
  - Required: pll_reset low at cycle 4.
  - Required: rst_out goes 111→110→100→000 at 2-cycle spacing, then ready=1.
- Glitchy lock: lock toggles every 5 cycles with STABLE_CYCLES=8.
  - Required: stability counter never completes and rst_out stays 111.
  - Required: after the lock is held, the sequence proceeds as in the normal-lock case.
- Timeout and fail: lock tied low, TIMEOUT_CYCLES=32, MAX_RETRY=2.
  - Required: two PLL_RST pulses, retry_cnt reaches 2.
  - Required: fail=1 and pll_reset=1 held.
  - Required: a restart pulse clears retry_cnt and re-sequences.
- Lock loss in RUN: drop lock for 1 cycle while in RUN.
  - Required: lock_lost=1, rst_out=111 within 3 cycles of the drop, pll_reset pulses.
  - Required: the sequence re-locks and lock_lost stays 1 until restart.
- Simultaneous events: stability completes on the same cycle as the timeout → RELEASE is taken and retry_cnt is unchanged. Restart asserted during RELEASE → PLL_RST is taken and rst_out=111 on the next cycle.
- Async reset: assert reset mid-RELEASE between clock edges.
  - Required: rst_out=111 and pll_reset=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL power-up sequencer: drives the PLL reset, qualifies the asynchronous
// lock with a synchroniser plus stability filter, retries on lock timeout and
// releases the per-domain resets one after another once the PLL is stable.
module pll_reset_sequencer #(
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRY      = 7,
    parameter int N_OUT          = 3,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic             i_clkin,
    input  logic             i_reset,
    input  logic             i_lock,
    input  logic             i_restart,
    output logic             o_pll_reset,
    output logic [N_OUT-1:0] o_rst_out,
    output logic             o_ready,
    output logic             o_fail,
    output logic [2:0]       o_retry_cnt,
    output logic             o_lock_lost
);

    // Release count at which the last domain reset drops; RUN follows one cycle later.
    localparam int REL_LAST = (N_OUT - 1) * STAGGER_CYCLES;
    localparam int CNT_A    = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_MAX  = (CNT_A > REL_LAST + 1) ? CNT_A : REL_LAST + 1;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int SW       = $clog2(STABLE_CYCLES + 1);

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] REL_END   = CW'(REL_LAST);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [2:0]    RETRY_MAX = 3'((MAX_RETRY > 7) ? 7 : MAX_RETRY);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;     // shared phase counter: reset hold, timeout, release
    logic [SW-1:0]    r_stab, w_stab_nxt;   // consecutive lock_s-high cycles
    logic [2:0]       r_retry, w_retry_nxt;
    logic             r_lost, w_lost_nxt;
    logic             r_lock_meta, r_lock_s;
    logic             r_pll_reset, r_ready, r_fail;
    logic [N_OUT-1:0] r_rst_out, w_rst_nxt;

    // Two-flop synchroniser for the raw PLL lock.
    always_ff @(posedge i_clkin or posedge i_reset) begin
        if (i_reset) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= i_lock;
            r_lock_s    <= r_lock_meta;
        end
    end

    // Next-state, counters and next output values; restart overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stab_nxt  = '0;
        w_retry_nxt = r_retry;
        w_lost_nxt  = r_lost;
        w_rst_nxt   = '1;

        if (i_restart) begin
            w_state_nxt = S_PLL_RST;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
            w_lost_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_PLL_RST: begin
                    if (r_cnt == RST_LAST) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    // Stability wins over a timeout landing on the same cycle.
                    if (r_lock_s && (r_stab == STAB_LAST)) begin
                        w_state_nxt = S_RELEASE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == TO_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_retry < RETRY_MAX) begin
                            w_retry_nxt = r_retry + 3'd1;
                            w_state_nxt = S_PLL_RST;
                        end else begin
                            w_state_nxt = S_FAIL;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                        if (r_lock_s) w_stab_nxt = r_stab + SW'(1);
                    end
                end
                S_RELEASE: begin
                    if (!r_lock_s) begin
                        w_state_nxt = S_PLL_RST;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == REL_END) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                S_RUN: begin
                    if (!r_lock_s) begin
                        w_lost_nxt  = 1'b1;
                        w_state_nxt = S_PLL_RST;
                        w_cnt_nxt   = '0;
                    end
                end
                S_FAIL: begin
                    w_state_nxt = S_FAIL;
                end
                default: begin
                    w_state_nxt = S_PLL_RST;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // Domain resets drop one by one by release count; they only ever rise together.
        if (w_state_nxt == S_RELEASE) begin
            for (int i = 0; i < N_OUT; i++)
                w_rst_nxt[i] = int'(w_cnt_nxt) < i * STAGGER_CYCLES;
        end else if (w_state_nxt == S_RUN) begin
            w_rst_nxt = '0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clkin or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= '0;
            r_stab      <= '0;
            r_retry     <= '0;
            r_lost      <= 1'b0;
            r_pll_reset <= 1'b1;
            r_rst_out   <= '1;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_stab      <= w_stab_nxt;
            r_retry     <= w_retry_nxt;
            r_lost      <= w_lost_nxt;
            r_pll_reset <= (w_state_nxt == S_PLL_RST) || (w_state_nxt == S_FAIL);
            r_rst_out   <= w_rst_nxt;
            r_ready     <= (w_state_nxt == S_RUN);
            r_fail      <= (w_state_nxt == S_FAIL);
        end
    end

    assign o_pll_reset = r_pll_reset;
    assign o_rst_out   = r_rst_out;
    assign o_ready     = r_ready;
    assign o_fail      = r_fail;
    assign o_retry_cnt = r_retry;
    assign o_lock_lost = r_lost;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: the driver steps a phase/elapsed-time
// reference model per clock and queues expected outputs; a monitor compares.
module tb_pll_reset_sequencer;

    localparam int RSTC = 4;
    localparam int STAB = 8;
    localparam int TO   = 32;
    localparam int MAXR = 2;
    localparam int N    = 3;
    localparam int STG  = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         lock = 1'b0;
    logic         restart = 1'b0;
    logic         pll_reset, ready, fail, lock_lost;
    logic [N-1:0] rst_out;
    logic [2:0]   retry_cnt;

    pll_reset_sequencer #(
        .RST_CYCLES(RSTC), .STABLE_CYCLES(STAB), .TIMEOUT_CYCLES(TO),
        .MAX_RETRY(MAXR), .N_OUT(N), .STAGGER_CYCLES(STG)
    ) dut (
        .i_clkin(clk), .i_reset(rst), .i_lock(lock), .i_restart(restart),
        .o_pll_reset(pll_reset), .o_rst_out(rst_out), .o_ready(ready),
        .o_fail(fail), .o_retry_cnt(retry_cnt), .o_lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         pll_reset;
        logic [N-1:0] rst_out;
        logic         ready;
        logic         fail;
        logic [2:0]   retry;
        logic         lost;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: phase, cycles elapsed in phase, lock history.
    typedef enum {M_RST, M_WAIT, M_REL, M_RUN, M_FAIL} ph_t;
    ph_t ph;
    int  t, run, retries;
    bit  lost, h1, h2;

    task automatic m_reset();
        ph = M_RST; t = 0; run = 0; retries = 0; lost = 0; h1 = 0; h2 = 0;
    endtask

    function automatic exp_t m_out();
        exp_t e;
        e.pll_reset = (ph == M_RST) || (ph == M_FAIL);
        for (int i = 0; i < N; i++)
            e.rst_out[i] = (ph == M_REL) ? (t < i * STG) : (ph != M_RUN);
        e.ready = (ph == M_RUN);
        e.fail  = (ph == M_FAIL);
        e.retry = 3'(retries);
        e.lost  = lost;
        return e;
    endfunction

    task automatic m_edge(input bit lk, input bit rs);
        bit ls;
        ls = h2; h2 = h1; h1 = lk;   // decisions see lock from two edges ago
        if (rs) begin
            ph = M_RST; t = 0; retries = 0; lost = 0;
        end else begin
            case (ph)
                M_RST: begin
                    t++;
                    if (t == RSTC) begin ph = M_WAIT; t = 0; run = 0; end
                end
                M_WAIT: begin
                    run = ls ? run + 1 : 0;
                    t++;
                    if (run == STAB) begin
                        ph = M_REL; t = 0;
                    end else if (t == TO) begin
                        t = 0;
                        if (retries < MAXR) begin retries++; ph = M_RST; end
                        else ph = M_FAIL;
                    end
                end
                M_REL: begin
                    if (!ls) begin ph = M_RST; t = 0; end
                    else begin
                        t++;
                        if (t == (N - 1) * STG + 1) begin ph = M_RUN; t = 0; end
                    end
                end
                M_RUN: begin
                    if (!ls) begin lost = 1; ph = M_RST; t = 0; end
                end
                default: ;
            endcase
        end
    endtask

    // One clock of stimulus: drive inputs away from the edge, queue the expected result.
    task automatic drive(input bit lk, input bit rs, input bit rr);
        @(negedge clk);
        lock = lk; restart = rs; rst = rr;
        if (rr) m_reset();
        else m_edge(lk, rs);
        q.push_back(m_out());
        cyc++;
    endtask

    task automatic hold(input bit lk, input int n);
        for (int k = 0; k < n; k++) drive(lk, 1'b0, 1'b0);
    endtask

    // Monitor: compare every registered output set one step after the edge.
    initial begin
        exp_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                g.pll_reset = pll_reset; g.rst_out = rst_out; g.ready = ready;
                g.fail = fail; g.retry = retry_cnt; g.lost = lock_lost;
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got pll_reset=%b rst_out=%b ready=%b fail=%b retry=%0d lost=%b exp pll_reset=%b rst_out=%b ready=%b fail=%b retry=%0d lost=%b",
                             cyc, g.pll_reset, g.rst_out, g.ready, g.fail, g.retry, g.lost,
                             e.pll_reset, e.rst_out, e.ready, e.fail, e.retry, e.lost);
                end
            end
        end
    end

    initial begin
        int  n;
        bit  found;
        m_reset();
        #1 rst = 1'b1;
        #1;
        total++;
        if ({pll_reset, rst_out, ready, fail, retry_cnt, lock_lost} !== {1'b1, {N{1'b1}}, 1'b0, 1'b0, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got pll_reset=%b rst_out=%b ready=%b fail=%b retry=%0d lost=%b", pll_reset, rst_out, ready, fail, retry_cnt, lock_lost);
        end
        for (int k = 0; k < 3; k++) drive(0, 0, 1);

        // Normal lock: lock rises 10 cycles after reset release.
        hold(0, 10);
        hold(1, 40);

        // Glitchy lock, then a solid lock.
        drive(0, 1, 0);
        for (int k = 0; k < 60; k++) drive(((k / 5) % 2) == 1, 0, 0);
        hold(1, 60);

        // One-cycle lock drop in RUN, then re-lock.
        hold(0, 1);
        hold(1, 40);

        // Lock stuck low: retries exhaust into FAIL; restart recovers.
        hold(0, 150);
        drive(0, 1, 0);
        hold(0, 5);
        hold(1, 40);

        // Stability completes on the timeout cycle; then restart mid-RELEASE.
        hold(0, 3);
        drive(0, 1, 0);
        hold(0, 26);
        hold(1, 11);
        drive(1, 1, 0);
        hold(1, 30);

        // Asynchronous reset between edges during RELEASE.
        drive(1, 1, 0);
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            drive(1, 0, 0);
            if (ph == M_REL && t == 1) found = 1;
        end
        if (!found) begin
            total++; bad++;
            $display("FAIL release_wait got no RELEASE within 60 cycles exp RELEASE");
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (rst_out !== {N{1'b1}} || pll_reset !== 1'b1 || ready !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got rst_out=%b pll_reset=%b ready=%b exp rst_out=%b pll_reset=1 ready=0", rst_out, pll_reset, ready, {N{1'b1}});
        end
        for (int k = 0; k < 3; k++) drive(1, 0, 1);
        hold(1, 40);

        // Randomised segments.
        for (int s = 0; s < 50; s++) begin
            n = $urandom_range(5, 70);
            case ($urandom_range(0, 4))
                0: hold(1, n);
                1: hold(0, n);
                2: for (int k = 0; k < n; k++) drive(($urandom_range(0, 3) != 0), 0, 0);
                3: begin hold(0, $urandom_range(1, 3)); hold(1, n); end
                default: for (int k = 0; k < n; k++)
                    drive($urandom_range(0, 1) == 1, ($urandom_range(0, 40) == 0), 0);
            endcase
        end

        @(posedge clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got %0d pending exp 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
